powlib_fifo_unpack: RTL and testbench
=====================================

Name: powlib_fifo_unpack

Overview:
- Read-side consumer for powlib_sfifo/powlib_afifo: drains wide words from a FIFO read port (rddata/rdvld/rdrdy) and re-emits each word as N narrow beats on a valid/ready stream, flagging the final beat with outlast.
- Sits between a wide-storage FIFO and a narrow datapath, for example bus-width reduction or byte serialisation.
- Sustains full throughput: one narrow beat per clock with no bubbles between words.

Parameters:
- W, 8: narrow output beat width in bits.
- N, 4: beats per input word; input width is W*N; N>=2.
- MSBF, 0: 0 emits the least-significant slice first; 1 emits the most-significant slice first.
- EDBG, 0: enables debug statements and parameter checks.
- ID, "UNPACK": string identifier for debug output.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- indata  input  W*N  wide word; connects to FIFO rddata.
- invld  input  1  wide word valid; connects to FIFO rdvld.
- inrdy  output  1  wide word accepted this cycle when invld&&inrdy; connects to FIFO rdrdy.
- outdata  output  W  current narrow beat.
- outvld  output  1  outdata valid.
- outrdy  input  1  downstream ready; a beat transfers when outvld&&outrdy.
- outlast  output  1  high with the final beat (index N-1) of each word.

Behaviour:
State:
- Hold register hreg[W*N-1:0].
- Occupancy flag full.
- Beat counter cnt of width powlib_clogb2(N), counting 0..N-1.

Reset (asynchronous, immediate on rst=1):
- hreg=0, full=0, cnt=0.
- Outputs: outvld=0, outlast=0, outdata=0, inrdy=1.

Combinational outputs:
- outvld = full.
- outlast = full && (cnt==N-1).
- outfire = outvld && outrdy.
- inrdy = !full || (outfire && outlast).
- infire = invld && inrdy.
- outdata = hreg slice cnt, i.e. bits [cnt*W +: W] when MSBF=0, or bits [(N-1-cnt)*W +: W] when MSBF=1.
- inrdy depends on outrdy combinationally; there is no path from invld to any output.

Sequential updates:
- infire: hreg<=indata, full<=1, cnt<=0.
- outfire && !outlast: cnt<=cnt+1.
- outfire && outlast && !infire: full<=0, cnt<=0.
- outfire && outlast && infire: the load takes priority, so the next word follows back-to-back with no bubble.
- full && !outrdy: hreg, cnt and outdata are held stable; outvld stays high and is never withdrawn without a transfer.

Latency and throughput:
- A word accepted in cycle t presents beat 0 in cycle t+1.
- With invld=1 and outrdy=1 held continuously, outvld stays 1 every cycle after the first load.
- inrdy pulses once every N cycles, coincident with outlast.

Counter and boundaries:
- The counter wraps explicitly at N-1, so N need not be a power of 2. With N=3, for example, cnt runs 0,1,2,0.
- Empty (full=0): outvld=0, and outdata shows slice 0 of the stale hreg; its value is don't-care.
- invld=0 at the last beat: full clears and outvld drops in the next cycle.
- Reset mid-word: the partially sent word is discarded and no beats are emitted after reset. The upstream FIFO is not rewound.

Debug (EDBG!=0):
- At time 0, if N<2, display ID and N, then $finish.
- On every infire, display ID and indata.

Test Plan:
- Reset then idle: rst=1 for 3 cycles with invld=0 -> outvld=0, outlast=0, inrdy=1, outdata=0 during and after reset.
- Single word (W=8, N=4, MSBF=0): indata=32'hDDCCBBAA, one-cycle invld, outrdy=1 -> outdata AA,BB,CC,DD in cycles t+1..t+4; outlast only on DD; outvld=0 at t+5.
- Back-to-back words with outrdy=1: words 32'h03020100 then 32'h07060504 -> 8 consecutive beats 00..07 with no gap; inrdy high only at reset-idle and on the beat-03 cycle; outlast on 03 and 07.
- Backpressure: word 32'h44332211 with outrdy=0 for 5 cycles after beat 22 appears -> outdata holds 22 and outvld=1 throughout, cnt unchanged, inrdy=0; sequence resumes 33, 44 when outrdy=1.
- MSBF=1 and N=3 (W=8): indata=24'hC0B0A0 -> beats C0,B0,A0 with outlast on A0; counter wraps 0,1,2,0 on the next word 24'h030201 -> 03,02,01.
- Reset mid-word: assert rst asynchronously (between clock edges) after beat BB of 32'hDDCCBBAA -> outvld falls immediately without waiting for a clock edge; no CC/DD emitted; the next word 32'h12345678 starts cleanly with beat 78.

Source files
------------

// File: rtl/powlib_fifo_unpack.sv
// Wide-to-narrow unpacker. It reads one wide word from a FIFO read port
// and re-emits it as N narrow beats on a valid/ready stream. outlast marks
// the final beat of each word. Full throughput, with no bubble between words.
module powlib_fifo_unpack #(
    parameter int unsigned W    = 8,
    parameter int unsigned N    = 4,
    parameter int unsigned MSBF = 0,
    parameter int unsigned EDBG = 0,
    parameter string       ID   = "UNPACK"
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W*N-1:0] indata,
    input  logic           invld,
    output logic           inrdy,
    output logic [W-1:0]   outdata,
    output logic           outvld,
    input  logic           outrdy,
    output logic           outlast
);

    localparam int unsigned DW = W * N;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    // Elaboration-time sanity check on the beat count
    if (EDBG != 0 && N < 2) begin : g_bad_n
        $error("%s: N=%0d must be at least 2", ID, N);
    end

    logic [DW-1:0] hreg, hreg_nxt;
    logic          full, full_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] sel;
    logic          outfire;
    logic          infire;
    logic [W-1:0]  slices [N];

    // Handshake decode. inrdy opens on the last beat, so the next word loads back-to-back
    always_comb begin
        outvld  = full;
        outlast = full && (cnt == CW'(N - 1));
        outfire = full && outrdy;
        inrdy   = !full || (outfire && outlast);
        infire  = invld && inrdy;
    end

    // Split the hold register into beat-sized slices
    for (genvar g = 0; g < N; g++) begin : g_slice
        assign slices[g] = hreg[g*W +: W];
    end

    // Beat select: cnt walks the slices upward, or downward when MSBF is set
    always_comb begin
        sel     = (MSBF != 0) ? (CW'(N - 1) - cnt) : cnt;
        outdata = slices[sel];
    end

    // Next state: advance on each beat, empty after the last, and let a load take priority
    always_comb begin
        hreg_nxt = hreg;
        full_nxt = full;
        cnt_nxt  = cnt;
        if (outfire) begin
            if (outlast) begin
                full_nxt = 1'b0;
                cnt_nxt  = '0;
            end else begin
                cnt_nxt  = cnt + CW'(1);
            end
        end
        if (infire) begin
            hreg_nxt = indata;
            full_nxt = 1'b1;
            cnt_nxt  = '0;
        end
    end

    // State registers. Reset discards any partially sent word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hreg <= '0;
            full <= 1'b0;
            cnt  <= '0;
        end else begin
            hreg <= hreg_nxt;
            full <= full_nxt;
            cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_powlib_fifo_unpack.sv
// Bench for powlib_fifo_unpack. It drives two instances: (W=8,N=4,LSB first)
// and (W=8,N=3,MSB first). A beats-remaining model predicts the outputs.
module tb_powlib_fifo_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tin  [2];
    logic        tvld [2];
    logic        trdy [2];

    logic [7:0]  od_a, od_b;
    logic        ov_a, ov_b, ol_a, ol_b, ir_a, ir_b;
    logic [7:0]  od [2];
    logic        ov [2];
    logic        ol [2];
    logic        ir [2];

    assign od[0] = od_a;  assign od[1] = od_b;
    assign ov[0] = ov_a;  assign ov[1] = ov_b;
    assign ol[0] = ol_a;  assign ol[1] = ol_b;
    assign ir[0] = ir_a;  assign ir[1] = ir_b;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    powlib_fifo_unpack #(.W(8), .N(4), .MSBF(0)) dut_a (
        .clk(clk), .rst(rst),
        .indata(tin[0]), .invld(tvld[0]), .inrdy(ir_a),
        .outdata(od_a), .outvld(ov_a), .outrdy(trdy[0]), .outlast(ol_a)
    );

    powlib_fifo_unpack #(.W(8), .N(3), .MSBF(1)) dut_b (
        .clk(clk), .rst(rst),
        .indata(tin[1][23:0]), .invld(tvld[1]), .inrdy(ir_b),
        .outdata(od_b), .outvld(ov_b), .outrdy(trdy[1]), .outlast(ol_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nn(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic logic [31:0] wmask(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
    endfunction

    // Model: the word being emitted and how many of its beats are still owed
    logic [31:0] mword [2] = '{32'h0, 32'h0};
    int          mleft [2] = '{0, 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mword[i] = 32'h0;
                mleft[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit fo, fi;
                fo = (mleft[i] > 0) && trdy[i];
                fi = tvld[i] && ((mleft[i] == 0) || (trdy[i] && mleft[i] == 1));
                if (fo) mleft[i] = mleft[i] - 1;
                if (fi) begin
                    mword[i] = tin[i] & wmask(i);
                    mleft[i] = nn(i);
                end
            end
        end
    end

    // Compare all outputs against the model on every falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int k, s;
            logic [31:0] sh;
            k  = (mleft[i] > 0) ? (nn(i) - mleft[i]) : 0;
            s  = (i == 1) ? (nn(i) - 1 - k) : k;
            sh = mword[i] >> (8 * s);
            chk($sformatf("dut%0d_outvld", i),  32'(ov[i]), 32'(mleft[i] > 0));
            chk($sformatf("dut%0d_outlast", i), 32'(ol[i]), 32'(mleft[i] == 1));
            chk($sformatf("dut%0d_inrdy", i),   32'(ir[i]),
                32'((mleft[i] == 0) || (trdy[i] && mleft[i] == 1)));
            chk($sformatf("dut%0d_outdata", i), 32'(od[i]), 32'(sh[7:0]));
        end
    end

    // Record transferred beats for the literal sequence checks
    bit         log_en = 1'b1;
    logic [7:0] loga [$];
    logic [7:0] logb [$];

    always @(negedge clk) begin
        if (log_en && !rst) begin
            if (ov_a && trdy[0]) loga.push_back(od_a);
            if (ov_b && trdy[1]) logb.push_back(od_b);
        end
    end

    // Present a word and hold it until the instance accepts it
    task automatic send(input int i, input logic [31:0] w);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        tin[i]  = w;
        tvld[i] = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = ir[i];
            @(posedge clk); #1;
            n++;
            if (!done && n > 50) begin
                ntests++;
                nfail++;
                $display("FAIL send_timeout dut%0d: inrdy stayed %b, required 1", i, ir[i]);
                done = 1'b1;
            end
        end
        tvld[i] = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk); #1;
        end
    endtask

    logic [7:0] exp_a [] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD,
                             8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                             8'h11, 8'h22, 8'h33, 8'h44,
                             8'hAA,
                             8'h78, 8'h56, 8'h34, 8'h12};
    logic [7:0] exp_b [] = '{8'hC0, 8'hB0, 8'hA0, 8'h03, 8'h02, 8'h01};

    initial begin
        for (int i = 0; i < 2; i++) begin
            tin[i]  = 32'h0;
            tvld[i] = 1'b0;
            trdy[i] = 1'b1;
        end
        rst = 1'b1;

        // Reset with the inputs idle
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outvld",  32'(ov_a), 32'h0);
        chk("reset_inrdy",   32'(ir_a), 32'h1);
        chk("reset_outdata", 32'(od_a), 32'h0);
        rst = 1'b0;
        idle(2);

        // Single word, then two back-to-back words
        send(0, 32'hDDCC_BBAA);
        idle(6);
        send(0, 32'h0302_0100);
        send(0, 32'h0706_0504);
        idle(6);

        // Backpressure while beat 22 is showing
        send(0, 32'h4433_2211);
        @(posedge clk); #1;
        trdy[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_outdata", 32'(od_a), 32'h22);
            chk("hold_outvld",  32'(ov_a), 32'h1);
            chk("hold_inrdy",   32'(ir_a), 32'h0);
            @(posedge clk); #1;
        end
        trdy[0] = 1'b1;
        idle(5);

        // Reset arrives between edges while beat BB is showing
        send(0, 32'hDDCC_BBAA);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_outvld",  32'(ov_a), 32'h0);
        chk("async_rst_outdata", 32'(od_a), 32'h0);
        chk("async_rst_inrdy",   32'(ir_a), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        send(0, 32'h1234_5678);
        idle(6);

        // MSB-first, N=3, with the counter wrapping into the next word
        send(1, 32'h00C0_B0A0);
        send(1, 32'h0003_0201);
        idle(5);

        log_en = 1'b0;
        chk("loga_len", 32'(loga.size()), 32'(exp_a.size()));
        for (int j = 0; j < exp_a.size() && j < loga.size(); j++)
            chk($sformatf("loga_beat%0d", j), 32'(loga[j]), 32'(exp_a[j]));
        chk("logb_len", 32'(logb.size()), 32'(exp_b.size()));
        for (int j = 0; j < exp_b.size() && j < logb.size(); j++)
            chk($sformatf("logb_beat%0d", j), 32'(logb[j]), 32'(exp_b[j]));

        // Saturated streaming: both sides always ready
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < 2; i++) begin
                tin[i]  = $urandom;
                tvld[i] = 1'b1;
                trdy[i] = 1'b1;
            end
            @(posedge clk); #1;
        end

        // Random valid/ready traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                tin[i]  = $urandom;
                tvld[i] = ($urandom_range(0, 1) == 1);
                trdy[i] = ($urandom_range(0, 3) != 0);
            end
            if (c % 997 == 500) begin
                #2 rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end

        for (int i = 0; i < 2; i++) tvld[i] = 1'b0;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
